// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM stage: RV32I funct3 load/store codes, FSM states,
// lane widths and the alignment helper used by the optional misalignment trap.
package mem_stage_pkg;

    localparam int BE_W   = 4;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = 8;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    // funct3[1:0] encodes the access size for loads and stores alike: 00 byte, 01 half, 10 word.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Extracts the addressed byte/half/word lane from a load's read data and applies
// sign or zero extension according to funct3.
module load_formatter
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [BYTE_W-1:0]   sel_byte;
    logic [2*BYTE_W-1:0] sel_half;

    always_comb begin
        sel_byte = rdata[{addr_lo, 3'b000} +: BYTE_W];
        sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   result = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU:  result = {24'h0, sel_byte};
            F3_LH:   result = {{16{sel_half[15]}}, sel_half};
            F3_LHU:  result = {16'h0, sel_half};
            F3_LW:   result = rdata;
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM pipeline stage: data-memory handshake with ack timeout, store lane steering,
// load formatting and the MEM/WB register. Optional macro MISALIGN_TRAP_EN adds Misalign_Trap.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Valid_MEM,
    input  logic [31:0]     Alu_Out_MEM,
    input  logic [31:0]     Store_Data_MEM,
    input  logic [31:0]     PC_MEM,
    input  logic            Mem_Read_MEM,
    input  logic            Mem_Write_MEM,
    input  logic [2:0]      Funct3_MEM,
    input  logic            Write_Back_Control_MEM,
    input  logic            Write_Enable_MEM,
    input  logic [4:0]      Rd_MEM,
    output logic            Dmem_Req,
    output logic            Dmem_We,
    output logic [31:0]     Dmem_Addr,
    output logic [31:0]     Dmem_Wdata,
    output logic [BE_W-1:0] Dmem_Be,
    input  logic            Dmem_Ack,
    input  logic [31:0]     Dmem_Rdata,
    output logic            Stall_MEM,
    output logic [31:0]     Alu_Out_WB,
    output logic [31:0]     PC_WB,
    output logic [31:0]     Loaded_Data_WB,
    output logic            Write_Back_Control_WB,
    output logic            Write_Enable_WB,
    output logic            Valid_WB,
    output logic [4:0]      Rd_WB,
`ifdef MISALIGN_TRAP_EN
    output logic            Misalign_Trap,
`endif
    output logic            Bus_Err
);

    mem_state_e       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             misalign;
    logic             mem_op;
    logic             timeout;
    logic             retire;
    logic [31:0]      load_result;

`ifdef MISALIGN_TRAP_EN
    assign misalign      = Valid_MEM & (Mem_Read_MEM | Mem_Write_MEM)
                         & is_misaligned(Funct3_MEM, Alu_Out_MEM[1:0]);
    assign Misalign_Trap = misalign;
`else
    assign misalign      = 1'b0;
`endif

    // A timed-out access drops its request, which also releases the stall so the
    // instruction retires (without a register write) on this same edge.
    assign mem_op    = Valid_MEM & (Mem_Read_MEM | Mem_Write_MEM) & ~misalign;
    assign timeout   = (state == ST_WAIT) && (wait_cnt == CNT_W'(ACK_TIMEOUT - 1));
    assign Bus_Err   = timeout & mem_op;
    assign Dmem_Req  = mem_op & ~timeout;
    assign Stall_MEM = Dmem_Req & ~Dmem_Ack;
    assign retire    = Valid_MEM & ~Stall_MEM;
    assign Dmem_We   = Dmem_Req & Mem_Write_MEM;
    assign Dmem_Addr = {Alu_Out_MEM[31:2], 2'b00};

    always_comb begin
        Dmem_Be    = '1;
        Dmem_Wdata = Store_Data_MEM;
        if (Mem_Write_MEM) begin
            case (Funct3_MEM)
                F3_SB: begin
                    Dmem_Be    = 4'b0001 << Alu_Out_MEM[1:0];
                    Dmem_Wdata = {4{Store_Data_MEM[7:0]}};
                end
                F3_SH: begin
                    Dmem_Be    = Alu_Out_MEM[1] ? 4'b1100 : 4'b0011;
                    Dmem_Wdata = {2{Store_Data_MEM[15:0]}};
                end
                F3_SW:   Dmem_Be = '1;
                default: Dmem_Be = '1;
            endcase
        end
    end

    load_formatter u_load_formatter (
        .rdata   (Dmem_Rdata),
        .addr_lo (Alu_Out_MEM[1:0]),
        .funct3  (Funct3_MEM),
        .result  (load_result)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Dmem_Req && !Dmem_Ack) begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (!mem_op || Dmem_Ack || timeout) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Data fields load every cycle; only Valid_WB/Write_Enable_WB distinguish a bubble.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Valid_WB              <= 1'b0;
            Write_Enable_WB       <= 1'b0;
            Write_Back_Control_WB <= 1'b0;
            Alu_Out_WB            <= '0;
            PC_WB                 <= '0;
            Loaded_Data_WB        <= '0;
            Rd_WB                 <= '0;
        end else begin
            Valid_WB              <= retire;
            Write_Enable_WB       <= retire & Write_Enable_MEM & ~Mem_Write_MEM & ~Bus_Err & ~misalign;
            Write_Back_Control_WB <= Write_Back_Control_MEM;
            Alu_Out_WB            <= Alu_Out_MEM;
            PC_WB                 <= PC_MEM;
            Loaded_Data_WB        <= load_result;
            Rd_WB                 <= Rd_MEM;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: table of zero-wait vectors plus hand-written
// wait-state, timeout, reset-during-wait and alignment sequences.
`timescale 1ns/1ps
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Valid_MEM;
    logic [31:0] Alu_Out_MEM, Store_Data_MEM, PC_MEM;
    logic        Mem_Read_MEM, Mem_Write_MEM;
    logic [2:0]  Funct3_MEM;
    logic        Write_Back_Control_MEM, Write_Enable_MEM;
    logic [4:0]  Rd_MEM;
    logic        Dmem_Req, Dmem_We;
    logic [31:0] Dmem_Addr, Dmem_Wdata;
    logic [3:0]  Dmem_Be;
    logic        Dmem_Ack;
    logic [31:0] Dmem_Rdata;
    logic        Stall_MEM;
    logic [31:0] Alu_Out_WB, PC_WB, Loaded_Data_WB;
    logic        Write_Back_Control_WB, Write_Enable_WB, Valid_WB;
    logic [4:0]  Rd_WB;
    logic        Bus_Err;
`ifdef MISALIGN_TRAP_EN
    logic        Misalign_Trap;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 Clk = ~Clk;

    mem_access_stage #(.ACK_TIMEOUT(16)) dut (
        .Clk                    (Clk),
        .Rst_n                  (Rst_n),
        .Valid_MEM              (Valid_MEM),
        .Alu_Out_MEM            (Alu_Out_MEM),
        .Store_Data_MEM         (Store_Data_MEM),
        .PC_MEM                 (PC_MEM),
        .Mem_Read_MEM           (Mem_Read_MEM),
        .Mem_Write_MEM          (Mem_Write_MEM),
        .Funct3_MEM             (Funct3_MEM),
        .Write_Back_Control_MEM (Write_Back_Control_MEM),
        .Write_Enable_MEM       (Write_Enable_MEM),
        .Rd_MEM                 (Rd_MEM),
        .Dmem_Req               (Dmem_Req),
        .Dmem_We                (Dmem_We),
        .Dmem_Addr              (Dmem_Addr),
        .Dmem_Wdata             (Dmem_Wdata),
        .Dmem_Be                (Dmem_Be),
        .Dmem_Ack               (Dmem_Ack),
        .Dmem_Rdata             (Dmem_Rdata),
        .Stall_MEM              (Stall_MEM),
        .Alu_Out_WB             (Alu_Out_WB),
        .PC_WB                  (PC_WB),
        .Loaded_Data_WB         (Loaded_Data_WB),
        .Write_Back_Control_WB  (Write_Back_Control_WB),
        .Write_Enable_WB        (Write_Enable_WB),
        .Valid_WB               (Valid_WB),
        .Rd_WB                  (Rd_WB),
`ifdef MISALIGN_TRAP_EN
        .Misalign_Trap          (Misalign_Trap),
`endif
        .Bus_Err                (Bus_Err)
    );

    typedef struct {
        logic        valid, rd, wr, we;
        logic [2:0]  f3;
        logic [4:0]  rdn;
        logic [31:0] addr, sdata, rdata;
        logic        ack;
        logic        exp_req, exp_dwe;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_vwb, exp_wewb;
        logic [31:0] exp_ld;
    } vec_t;

    vec_t vecs[$];

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic checkWord(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic rd, input logic wr, input logic we,
                                 input logic [2:0] f3, input logic [4:0] rdn, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic [31:0] rdata, input logic ack);
        Valid_MEM              = valid;
        Mem_Read_MEM           = rd;
        Mem_Write_MEM          = wr;
        Write_Enable_MEM       = we;
        Write_Back_Control_MEM = rd;
        Funct3_MEM             = f3;
        Rd_MEM                 = rdn;
        Alu_Out_MEM            = addr;
        PC_MEM                 = addr + 32'h1000;
        Store_Data_MEM         = sdata;
        Dmem_Rdata             = rdata;
        Dmem_Ack               = ack;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    // Load at 0x103 acked on the fourth request cycle: three stall cycles, then retirement.
    task automatic runWaitLoad(input string tag, input logic [2:0] f3, input logic [31:0] exp);
        int stalls;
        stalls = 0;
        @(negedge Clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, f3, 5'd12, 32'h103, 32'h0, 32'h80FF_FFFF, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            if (Stall_MEM) stalls++;
            @(posedge Clk);
            #1;
            checkBit($sformatf("%s bubble valid_wb c%0d", tag, c), Valid_WB, 1'b0);
            @(negedge Clk);
        end
        Dmem_Ack = 1'b1;
        #1;
        checkBit($sformatf("%s ack stall", tag), Stall_MEM, 1'b0);
        @(posedge Clk);
        #1;
        checkWord($sformatf("%s stall cycles", tag), stalls, 32'd3);
        checkBit($sformatf("%s valid_wb", tag), Valid_WB, 1'b1);
        checkBit($sformatf("%s we_wb", tag), Write_Enable_WB, 1'b1);
        checkWord($sformatf("%s loaded", tag), Loaded_Data_WB, exp);
        checkWord($sformatf("%s rd_wb", tag), 32'(Rd_WB), 32'd12);
        @(negedge Clk);
        idleInputs();
    endtask

    // LW never acked: Bus_Err expected on the 16th WAIT cycle (17th request cycle, index 16).
    task automatic runTimeout(input string tag, input logic [31:0] addr);
        int berr_at;
        int stalls;
        berr_at = -1;
        stalls  = 0;
        @(negedge Clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, F3_LW, 5'd9, addr, 32'h0, 32'h0, 1'b0);
        for (int c = 0; c < 40; c++) begin
            #1;
            if (Bus_Err) begin
                berr_at = c;
                break;
            end
            if (Stall_MEM) stalls++;
            @(negedge Clk);
        end
        checkWord($sformatf("%s bus_err cycle", tag), berr_at, 32'd16);
        checkWord($sformatf("%s stall cycles", tag), stalls, 32'd16);
        checkBit($sformatf("%s req at timeout", tag), Dmem_Req, 1'b0);
        checkBit($sformatf("%s stall at timeout", tag), Stall_MEM, 1'b0);
        @(posedge Clk);
        #1;
        checkBit($sformatf("%s valid_wb", tag), Valid_WB, 1'b1);
        checkBit($sformatf("%s we_wb", tag), Write_Enable_WB, 1'b0);
        checkBit($sformatf("%s bus_err pulse end", tag), Bus_Err, 1'b0);
        // Back in IDLE: the held LW raises a fresh request that completes normally.
        @(negedge Clk);
        #1;
        checkBit($sformatf("%s reissue req", tag), Dmem_Req, 1'b1);
        checkBit($sformatf("%s reissue stall", tag), Stall_MEM, 1'b1);
        Dmem_Ack   = 1'b1;
        Dmem_Rdata = 32'h0BAD_F00D;
        @(posedge Clk);
        #1;
        checkBit($sformatf("%s reissue valid_wb", tag), Valid_WB, 1'b1);
        checkWord($sformatf("%s reissue loaded", tag), Loaded_Data_WB, 32'h0BAD_F00D);
        @(negedge Clk);
        idleInputs();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Rst_n = 1'b0;
        idleInputs();

        //                 valid  rd    wr    we    f3      rdn    addr         sdata         rdata         ack   req   dwe   be       wdata         vwb   wewb  ld
        vecs.push_back(vec_t'{1'b1,1'b0,1'b0,1'b1,3'b000, 5'd5, 32'h0000_0010,32'h0,        32'h0,        1'b0,1'b0,1'b0,4'b0000,32'h0,        1'b1,1'b1,32'h0});
        vecs.push_back(vec_t'{1'b1,1'b0,1'b1,1'b1,F3_SB,  5'd1, 32'h0000_0101,32'h0000_00A5,32'h0,        1'b1,1'b1,1'b1,4'b0010,32'hA5A5_A5A5,1'b1,1'b0,32'h0});
        vecs.push_back(vec_t'{1'b1,1'b0,1'b1,1'b0,F3_SB,  5'd2, 32'h0000_0103,32'h1234_5677,32'h0,        1'b1,1'b1,1'b1,4'b1000,32'h7777_7777,1'b1,1'b0,32'h0});
        vecs.push_back(vec_t'{1'b1,1'b0,1'b1,1'b1,F3_SH,  5'd3, 32'h0000_0202,32'h1234_ABCD,32'h0,        1'b1,1'b1,1'b1,4'b1100,32'hABCD_ABCD,1'b1,1'b0,32'h0});
        vecs.push_back(vec_t'{1'b1,1'b0,1'b1,1'b1,F3_SH,  5'd3, 32'h0000_0200,32'h0000_5A5A,32'h0,        1'b1,1'b1,1'b1,4'b0011,32'h5A5A_5A5A,1'b1,1'b0,32'h0});
        vecs.push_back(vec_t'{1'b1,1'b0,1'b1,1'b1,F3_SW,  5'd4, 32'h0000_0300,32'hDEAD_BEEF,32'h0,        1'b1,1'b1,1'b1,4'b1111,32'hDEAD_BEEF,1'b1,1'b0,32'h0});
        vecs.push_back(vec_t'{1'b1,1'b1,1'b0,1'b1,F3_LB,  5'd6, 32'h0000_0100,32'h0,        32'h80FF_FF7F,1'b1,1'b1,1'b0,4'b1111,32'h0,        1'b1,1'b1,32'h0000_007F});
        vecs.push_back(vec_t'{1'b1,1'b1,1'b0,1'b1,F3_LB,  5'd7, 32'h0000_0103,32'h0,        32'h80FF_FFFF,1'b1,1'b1,1'b0,4'b1111,32'h0,        1'b1,1'b1,32'hFFFF_FF80});
        vecs.push_back(vec_t'{1'b1,1'b1,1'b0,1'b1,F3_LBU, 5'd8, 32'h0000_0103,32'h0,        32'h80FF_FFFF,1'b1,1'b1,1'b0,4'b1111,32'h0,        1'b1,1'b1,32'h0000_0080});
        vecs.push_back(vec_t'{1'b1,1'b1,1'b0,1'b1,F3_LH,  5'd9, 32'h0000_0102,32'h0,        32'h8001_1234,1'b1,1'b1,1'b0,4'b1111,32'h0,        1'b1,1'b1,32'hFFFF_8001});
        vecs.push_back(vec_t'{1'b1,1'b1,1'b0,1'b1,F3_LHU, 5'd10,32'h0000_0102,32'h0,        32'h8001_1234,1'b1,1'b1,1'b0,4'b1111,32'h0,        1'b1,1'b1,32'h0000_8001});
        vecs.push_back(vec_t'{1'b1,1'b1,1'b0,1'b1,F3_LH,  5'd11,32'h0000_0100,32'h0,        32'h8001_7FFE,1'b1,1'b1,1'b0,4'b1111,32'h0,        1'b1,1'b1,32'h0000_7FFE});
        vecs.push_back(vec_t'{1'b1,1'b1,1'b0,1'b1,F3_LBU, 5'd13,32'h0000_0101,32'h0,        32'h1122_3344,1'b1,1'b1,1'b0,4'b1111,32'h0,        1'b1,1'b1,32'h0000_0033});
        vecs.push_back(vec_t'{1'b1,1'b1,1'b0,1'b1,F3_LW,  5'd14,32'h0000_0104,32'h0,        32'hCAFE_F00D,1'b1,1'b1,1'b0,4'b1111,32'h0,        1'b1,1'b1,32'hCAFE_F00D});
        vecs.push_back(vec_t'{1'b0,1'b1,1'b0,1'b1,F3_LW,  5'd15,32'h0000_0108,32'h0,        32'h1111_1111,1'b1,1'b0,1'b0,4'b0000,32'h0,        1'b0,1'b0,32'h0});
        vecs.push_back(vec_t'{1'b1,1'b0,1'b0,1'b0,3'b000, 5'd16,32'h0000_0055,32'h0,        32'h0,        1'b0,1'b0,1'b0,4'b0000,32'h0,        1'b1,1'b0,32'h0});

        repeat (2) @(negedge Clk);
        #1;
        checkBit("reset valid_wb", Valid_WB, 1'b0);
        checkBit("reset we_wb", Write_Enable_WB, 1'b0);
        checkWord("reset alu_wb", Alu_Out_WB, 32'h0);
        checkWord("reset loaded_wb", Loaded_Data_WB, 32'h0);
        checkBit("reset bus_err", Bus_Err, 1'b0);
        checkBit("reset req", Dmem_Req, 1'b0);
        @(negedge Clk);
        Rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge Clk);
            applyStimulus(vecs[i].valid, vecs[i].rd, vecs[i].wr, vecs[i].we, vecs[i].f3, vecs[i].rdn,
                          vecs[i].addr, vecs[i].sdata, vecs[i].rdata, vecs[i].ack);
            #1;
            checkBit($sformatf("v%0d req", i), Dmem_Req, vecs[i].exp_req);
            checkBit($sformatf("v%0d stall", i), Stall_MEM, 1'b0);
            checkBit($sformatf("v%0d bus_err", i), Bus_Err, 1'b0);
            if (vecs[i].exp_req) begin
                checkWord($sformatf("v%0d addr", i), Dmem_Addr, {vecs[i].addr[31:2], 2'b00});
                checkWord($sformatf("v%0d be", i), 32'(Dmem_Be), 32'(vecs[i].exp_be));
                checkBit($sformatf("v%0d dmem_we", i), Dmem_We, vecs[i].exp_dwe);
            end
            if (vecs[i].wr)
                checkWord($sformatf("v%0d wdata", i), Dmem_Wdata, vecs[i].exp_wdata);
            @(posedge Clk);
            #1;
            checkBit($sformatf("v%0d valid_wb", i), Valid_WB, vecs[i].exp_vwb);
            checkBit($sformatf("v%0d we_wb", i), Write_Enable_WB, vecs[i].exp_wewb);
            if (vecs[i].exp_vwb) begin
                checkWord($sformatf("v%0d alu_wb", i), Alu_Out_WB, vecs[i].addr);
                checkWord($sformatf("v%0d pc_wb", i), PC_WB, vecs[i].addr + 32'h1000);
                checkWord($sformatf("v%0d rd_wb", i), 32'(Rd_WB), 32'(vecs[i].rdn));
                checkBit($sformatf("v%0d wbc_wb", i), Write_Back_Control_WB, vecs[i].rd);
            end
            if (vecs[i].exp_vwb && vecs[i].rd)
                checkWord($sformatf("v%0d loaded", i), Loaded_Data_WB, vecs[i].exp_ld);
        end
        @(negedge Clk);
        idleInputs();

        runWaitLoad("lb wait", F3_LB, 32'hFFFF_FF80);
        runWaitLoad("lbu wait", F3_LBU, 32'h0000_0080);
        runTimeout("timeout", 32'h0000_0400);

        // Reset asserted mid-WAIT, between clock edges.
        @(negedge Clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, F3_LW, 5'd21, 32'h0000_0444, 32'h0, 32'h0, 1'b0);
        repeat (3) @(negedge Clk);
        #2;
        Rst_n     = 1'b0;
        Valid_MEM = 1'b0;
        #1;
        checkBit("rst-wait valid_wb", Valid_WB, 1'b0);
        checkBit("rst-wait we_wb", Write_Enable_WB, 1'b0);
        checkWord("rst-wait alu_wb", Alu_Out_WB, 32'h0);
        checkWord("rst-wait rd_wb", 32'(Rd_WB), 32'h0);
        checkBit("rst-wait bus_err", Bus_Err, 1'b0);
        checkBit("rst-wait stall", Stall_MEM, 1'b0);
        @(negedge Clk);
        idleInputs();
        Rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk);
            #1;
            checkBit($sformatf("post-reset valid_wb c%0d", c), Valid_WB, 1'b0);
        end
        runTimeout("post-reset timeout", 32'h0000_0500);

`ifdef MISALIGN_TRAP_EN
        @(negedge Clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, F3_LW, 5'd22, 32'h0000_0101, 32'h0, 32'h1122_3344, 1'b0);
        #1;
        checkBit("trap lw req", Dmem_Req, 1'b0);
        checkBit("trap lw pulse", Misalign_Trap, 1'b1);
        checkBit("trap lw stall", Stall_MEM, 1'b0);
        @(posedge Clk);
        #1;
        checkBit("trap lw valid_wb", Valid_WB, 1'b1);
        checkBit("trap lw we_wb", Write_Enable_WB, 1'b0);
        @(negedge Clk);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, F3_SH, 5'd0, 32'h0000_0203, 32'h0000_BEEF, 32'h0, 1'b1);
        #1;
        checkBit("trap sh req", Dmem_Req, 1'b0);
        checkBit("trap sh pulse", Misalign_Trap, 1'b1);
        @(negedge Clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, F3_LW, 5'd23, 32'h0000_0100, 32'h0, 32'h5566_7788, 1'b1);
        #1;
        checkBit("aligned lw trap", Misalign_Trap, 1'b0);
        checkBit("aligned lw req", Dmem_Req, 1'b1);
        @(posedge Clk);
        #1;
        checkWord("aligned lw loaded", Loaded_Data_WB, 32'h5566_7788);
        checkBit("aligned lw we_wb", Write_Enable_WB, 1'b1);
`else
        @(negedge Clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, F3_LW, 5'd22, 32'h0000_0101, 32'h0, 32'h1122_3344, 1'b1);
        #1;
        checkBit("misaligned lw req", Dmem_Req, 1'b1);
        checkWord("misaligned lw addr", Dmem_Addr, 32'h0000_0100);
        checkWord("misaligned lw be", 32'(Dmem_Be), 32'hF);
        @(posedge Clk);
        #1;
        checkWord("misaligned lw loaded", Loaded_Data_WB, 32'h1122_3344);
        checkBit("misaligned lw we_wb", Write_Enable_WB, 1'b1);
        @(negedge Clk);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, F3_SH, 5'd0, 32'h0000_0203, 32'h0000_BEEF, 32'h0, 1'b1);
        #1;
        checkBit("misaligned sh req", Dmem_Req, 1'b1);
        checkWord("misaligned sh be", 32'(Dmem_Be), 32'hC);
        checkWord("misaligned sh wdata", Dmem_Wdata, 32'hBEEF_BEEF);
`endif
        @(negedge Clk);
        idleInputs();
        repeat (2) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: ACK_TIMEOUT, 16, maximum WAIT-state cycles without Dmem_Ack before a bus error is declared (range 1..255).
REQ-002 Clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Valid_MEM  in  1  instruction present in MEM.
REQ-005 Alu_Out_MEM  in  32  ALU result / effective address.
REQ-006 Store_Data_MEM  in  32  rs2 data for stores.
REQ-007 PC_MEM  in  32  instruction PC.
REQ-008 Mem_Read_MEM, Mem_Write_MEM  in  1 each  load / store (never both set).
REQ-009 Funct3_MEM  in  3  access size and signedness (RV32I encoding).
REQ-010 Write_Back_Control_MEM, Write_Enable_MEM  in  1 each  WB select, register-write enable.
REQ-011 Rd_MEM  in  5  destination register.
REQ-012 Dmem_Req, Dmem_We  out  1 each  memory request, write strobe.
REQ-013 Dmem_Addr  out  32  word-aligned address (bits 1:0 = 0); Dmem_Wdata  out  32; Dmem_Be  out  4  byte enables.
REQ-014 Dmem_Ack  in  1  access complete; Dmem_Rdata  in  32  valid with Dmem_Ack.
REQ-015 Stall_MEM  out  1  hold all upstream stages.
REQ-016 Alu_Out_WB, PC_WB, Loaded_Data_WB  out  32 each; Write_Back_Control_WB, Write_Enable_WB, Valid_WB  out  1 each; Rd_WB  out  5  MEM/WB pipeline register.
REQ-017 Bus_Err  out  1  one-cycle pulse on timeout.

Function
REQ-018 Memory op = Valid_MEM & (Mem_Read_MEM | Mem_Write_MEM); Dmem_Req SHALL equal memory op (combinational) in IDLE and WAIT.
REQ-019 Stall_MEM SHALL equal Dmem_Req & ~Dmem_Ack; upstream holds MEM inputs stable while high.
REQ-020 FSM states IDLE, WAIT: IDLE->WAIT on memory op without Dmem_Ack; WAIT->IDLE on Dmem_Ack or timeout; IDLE holds on ack in same cycle (zero-wait access).
REQ-021 WAIT counter SHALL clear on entry and increment per cycle; reaching ACK_TIMEOUT without ack SHALL pulse Bus_Err, drop Dmem_Req that cycle, retire the instruction with Write_Enable_WB=0.
REQ-022 Non-memory valid instruction SHALL reach WB registers one cycle later (latency 1); loads/stores retire the cycle after Dmem_Ack.
REQ-023 Cycles with Stall_MEM high or Valid_MEM low SHALL load a bubble: Valid_WB=0, Write_Enable_WB=0, other WB fields don't-care.
REQ-024 Stores: SB Be=0001<<a[1:0], Wdata=byte replicated x4; SH Be=0011<<(2*a[1]), Wdata=half replicated x2; SW Be=1111; Dmem_We=1.
REQ-025 Loads: LB/LH sign-extend, LBU/LHU zero-extend the lane selected by a[1:0]; LW passes word; Dmem_Be=1111, Dmem_We=0.
REQ-026 Stores SHALL retire with Write_Enable_WB=0 regardless of Write_Enable_MEM.
REQ-027 Dmem_Ack outside a request SHALL be ignored.

Reset
REQ-028 Rst_n low SHALL immediately force FSM to IDLE, counter 0, all WB outputs 0, Bus_Err 0; mid-transaction reset abandons the access with no retirement.
REQ-029 Dmem_Req remains combinational; upstream Valid_MEM is 0 during reset.

Configuration
REQ-030 Macro MISALIGN_TRAP_EN defined: port Misalign_Trap (out, 1) added; misaligned LH/LHU/SH (a[0]) or LW/SW (a[1:0]!=0) SHALL suppress Dmem_Req, pulse Misalign_Trap one cycle, retire with Write_Enable_WB=0, no stall.
REQ-031 Macro undefined: no Misalign_Trap port; misaligned accesses use lane rules of REQ-024/025 with surplus low address bits ignored.

Structure
REQ-032 Package mem_stage_pkg SHALL hold Funct3 load/store codes, FSM state enum, and byte-enable widths.
REQ-033 Sub-module load_formatter (combinational: Rdata, a[1:0], Funct3 -> 32-bit result) SHALL be instantiated once.

Verification
REQ-034 ADD result 0x0000_0010, rd=5 -> next cycle Alu_Out_WB=0x10, Rd_WB=5, Valid_WB=1, no stall.
REQ-035 LB a=0x103, Rdata=0x80FF_FFFF, ack after 3 cycles -> Stall_MEM 3 cycles, Loaded_Data_WB=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-036 SH a=0x202, data 0x1234_ABCD -> Dmem_Addr=0x200, Be=1100, Wdata=0xABCD_ABCD, Write_Enable_WB=0.
REQ-037 LW no ack for 16 cycles -> Bus_Err pulse on 16th WAIT cycle, Valid_WB=1, Write_Enable_WB=0, FSM IDLE.
REQ-038 Rst_n low during WAIT -> outputs 0 immediately, no Valid_WB after release.
REQ-039 MISALIGN_TRAP_EN, LW a=0x101 -> Dmem_Req=0, Misalign_Trap pulse, Write_Enable_WB=0.
